alu_seq: RTL and testbench

Parametrised sequential ALU for the bus-based datapath. It latches operands and opcode on `start` and returns a registered result with a one-cycle `done` pulse. Flags are registered and updated only when `flagsin` is set. The result drives the shared bus through a `sumout`-controlled tri-state output. Single-cycle ops complete in one clock; the optional multiplier is a WIDTH-cycle shift-add.

---
 rtl/alu_seq.sv | 220 ++++++++++++++++++++++
 tb/tb_alu_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential ALU: operands latched on start, registered result/flags, one-cycle done.
// Define ALU_SEQ_MUL_EN to build the WIDTH-cycle shift-add multiplier for op 111.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  input  logic             start_i,
  input  logic             flagsin_i,
  input  logic             sumout_i,
  output logic [WIDTH-1:0] out_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             cf_o,
  output logic             zf_o,
  output logic             nf_o,
  output logic             vf_o
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;

`ifdef ALU_SEQ_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b111;
  localparam int         CW     = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DONE = 2'd2
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cf_q, cf_d;
  logic             zf_q, zf_d;
  logic             nf_q, nf_d;
  logic             vf_q, vf_d;

`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               flagsin_q, flagsin_d;
  logic [2*WIDTH-1:0] acc_step;
`endif

  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cf;
  logic             alu_vf;

  assign add_w = {1'b0, a_i} + {1'b0, b_i};
  // Subtract as a + ~b + 1 so the carry-out doubles as "no borrow" (a >= b).
  assign sub_w = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    alu_res = '0;
    alu_cf  = 1'b0;
    alu_vf  = 1'b0;
    case (op_i)
      OP_ADD: begin
        alu_res = add_w[WIDTH-1:0];
        alu_cf  = add_w[WIDTH];
        alu_vf  = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (add_w[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_cf  = sub_w[WIDTH];
        alu_vf  = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (sub_w[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_AND: alu_res = a_i & b_i;
      OP_OR:  alu_res = a_i | b_i;
      OP_XOR: alu_res = a_i ^ b_i;
      OP_SHL: begin
        alu_res = {a_i[WIDTH-2:0], 1'b0};
        alu_cf  = a_i[WIDTH-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, a_i[WIDTH-1:1]};
        alu_cf  = a_i[0];
      end
      default: begin
        alu_res = '0;
        alu_cf  = 1'b0;
        alu_vf  = 1'b0;
      end
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    cf_d     = cf_q;
    zf_d     = zf_q;
    nf_d     = nf_q;
    vf_d     = vf_q;
`ifdef ALU_SEQ_MUL_EN
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    flagsin_d = flagsin_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
`ifdef ALU_SEQ_MUL_EN
          if (op_i == OP_MUL) begin
            state_d   = S_RUN;
            mcand_d   = {{WIDTH{1'b0}}, a_i};
            mplier_d  = b_i;
            acc_d     = '0;
            cnt_d     = CW'(WIDTH);
            flagsin_d = flagsin_i;
          end else begin
`else
          begin
`endif
            state_d  = S_DONE;
            result_d = alu_res;
            if (flagsin_i) begin
              cf_d = alu_cf;
              zf_d = (alu_res == '0);
              nf_d = alu_res[WIDTH-1];
              vf_d = alu_vf;
            end
          end
        end else begin
          state_d = S_IDLE;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      S_RUN: begin
        acc_d    = acc_step;
        mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        // Last step: the counter hits zero on this edge and the product is final.
        if (cnt_q == {{(CW-1){1'b0}}, 1'b1}) begin
          state_d  = S_DONE;
          result_d = acc_step[WIDTH-1:0];
          if (flagsin_q) begin
            cf_d = |acc_step[2*WIDTH-1:WIDTH];
            zf_d = (acc_step[WIDTH-1:0] == '0);
            nf_d = acc_step[WIDTH-1];
            vf_d = 1'b0;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      cf_q     <= 1'b0;
      zf_q     <= 1'b0;
      nf_q     <= 1'b0;
      vf_q     <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      flagsin_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      cf_q     <= cf_d;
      zf_q     <= zf_d;
      nf_q     <= nf_d;
      vf_q     <= vf_d;
`ifdef ALU_SEQ_MUL_EN
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      flagsin_q <= flagsin_d;
`endif
    end
  end

  assign out_o  = sumout_i ? result_q : {WIDTH{1'bz}};
  assign done_o = (state_q == S_DONE);
`ifdef ALU_SEQ_MUL_EN
  assign busy_o = (state_q == S_RUN);
`else
  assign busy_o = 1'b0;
`endif
  assign cf_o = cf_q;
  assign zf_o = zf_q;
  assign nf_o = nf_q;
  assign vf_o = vf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=8); expectations follow ALU_SEQ_MUL_EN when defined.
module tb_alu_seq;
  localparam int W = 8;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [W-1:0] a_i, b_i;
  logic [2:0]   op_i;
  logic         start_i, flagsin_i, sumout_i;
  wire  [W-1:0] out_o;
  logic         busy_o, done_o, cf_o, zf_o, nf_o, vf_o;

  alu_seq #(.WIDTH(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .a_i(a_i), .b_i(b_i), .op_i(op_i),
    .start_i(start_i), .flagsin_i(flagsin_i), .sumout_i(sumout_i),
    .out_o(out_o), .busy_o(busy_o), .done_o(done_o),
    .cf_o(cf_o), .zf_o(zf_o), .nf_o(nf_o), .vf_o(vf_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [W-1:0] res;
    logic         cf, zf, nf, vf;
  } exp_t;

  exp_t sb[$];
  logic m_cf = 1'b0, m_zf = 1'b0, m_nf = 1'b0, m_vf = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: returns {cf, vf, result}, computed with integer arithmetic.
  function automatic logic [W+1:0] ref_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int ua, ub, sa, sbv, s, sv;
    logic [W-1:0] res;
    logic c, v;
    ua = a; ub = b; sa = $signed(a); sbv = $signed(b);
    res = '0; c = 1'b0; v = 1'b0; s = 0; sv = 0;
    case (op)
      3'd0: begin s = ua + ub; res = s[W-1:0]; c = (s > 255); sv = sa + sbv; v = (sv > 127) || (sv < -128); end
      3'd1: begin res = a - b; c = (ua >= ub); sv = sa - sbv; v = (sv > 127) || (sv < -128); end
      3'd2: res = a & b;
      3'd3: res = a | b;
      3'd4: res = a ^ b;
      3'd5: begin res = {a[W-2:0], 1'b0}; c = a[W-1]; end
      3'd6: begin res = {1'b0, a[W-1:1]}; c = a[0]; end
      default: begin
`ifdef ALU_SEQ_MUL_EN
        s = ua * ub; res = s[W-1:0]; c = (s > 255);
`endif
      end
    endcase
    return {c, v, res};
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic fl, input bit inject = 1'b0);
    exp_t e;
    logic [W+1:0] r;
    int lat, exp_lat;
    bit is_mul;
    r = ref_op(op, a, b);
    if (fl) begin
      m_cf = r[W+1]; m_vf = r[W]; m_zf = (r[W-1:0] == '0); m_nf = r[W-1];
    end
    e.res = r[W-1:0]; e.cf = m_cf; e.zf = m_zf; e.nf = m_nf; e.vf = m_vf;
    sb.push_back(e);
`ifdef ALU_SEQ_MUL_EN
    is_mul = (op == 3'd7);
`else
    is_mul = 1'b0;
`endif
    exp_lat = is_mul ? W + 1 : 1;
    op_i = op; a_i = a; b_i = b; flagsin_i = fl; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    a_i = W'($urandom); b_i = W'($urandom); op_i = 3'($urandom); flagsin_i = 1'($urandom);
    lat = 1;
    while (!done_o && lat < 30) begin
      check("busy_during_mul", busy_o, 1);
      if (inject && lat == 3) begin
        start_i = 1'b1; op_i = 3'd0; a_i = 8'h01; b_i = 8'h01; flagsin_i = 1'b1;
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk_i);
      lat++;
    end
    start_i = 1'b0;
    check("latency", lat, exp_lat);
    check("busy_at_done", busy_o, 0);
    e = sb.pop_front();
    if (done_o) begin
      check("result", out_o, e.res);
      check("cf", cf_o, e.cf);
      check("zf", zf_o, e.zf);
      check("nf", nf_o, e.nf);
      check("vf", vf_o, e.vf);
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk_i);
    check("idle_done", done_o, 0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_out"}, out_o, 0);
    check({tag, "_flags"}, {cf_o, zf_o, nf_o, vf_o}, 4'b0000);
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; flagsin_i = 1'b0; sumout_i = 1'b1;
    a_i = '0; b_i = '0; op_i = '0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    check_cleared("reset");

    run_op(3'd0, 8'h38, 8'h21, 1'b1);
    idle_cycle();
    run_op(3'd1, 8'h38, 8'h21, 1'b1);
    run_op(3'd1, 8'h21, 8'h21, 1'b1);
    run_op(3'd0, 8'h7F, 8'h01, 1'b1);
    run_op(3'd1, 8'h80, 8'h01, 1'b1);
    run_op(3'd1, 8'h10, 8'h20, 1'b1);
    idle_cycle();

    run_op(3'd0, 8'hFF, 8'h01, 1'b1);
    run_op(3'd2, 8'h0F, 8'hF0, 1'b0);
    sumout_i = 1'b0;
    @(negedge clk_i);
    sumout_i = 1'b1;
    #1;
    check("sumout_comb", out_o, 8'h00);

    run_op(3'd3, 8'hA0, 8'h05, 1'b1);
    run_op(3'd4, 8'hAA, 8'hAA, 1'b1);
    run_op(3'd5, 8'h81, 8'h00, 1'b1);
    run_op(3'd6, 8'h81, 8'h00, 1'b1);
    idle_cycle();

    run_op(3'd7, 8'h0D, 8'h13, 1'b1);
    run_op(3'd7, 8'h20, 8'h10, 1'b1);
    idle_cycle();
    run_op(3'd7, 8'h0D, 8'h13, 1'b1, 1'b1);
    idle_cycle();

    // Reset asserted so it is sampled at E4 of a multiply.
    op_i = 3'd7; a_i = 8'h0D; b_i = 8'h13; flagsin_i = 1'b1; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    sb.delete();
    m_cf = 1'b0; m_zf = 1'b0; m_nf = 1'b0; m_vf = 1'b0;
    check_cleared("mid_reset");
    idle_cycle();
    run_op(3'd0, 8'h12, 8'h34, 1'b1);

    // Reset wins over a simultaneous start.
    op_i = 3'd0; a_i = 8'h05; b_i = 8'h05; flagsin_i = 1'b1; start_i = 1'b1; rst_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0; rst_i = 1'b0;
    m_cf = 1'b0; m_zf = 1'b0; m_nf = 1'b0; m_vf = 1'b0;
    check_cleared("rst_prio");

    for (int i = 0; i < 30; i++) begin
      run_op(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
